// File: rtl/ulpi_usb_tx.sv
// ULPI link-side transmit engine: TXCMD/NXT/STP sequencing for
// handshake and DATA0/DATA1 packets with CRC16 from a 64-byte buffer.
`timescale 1ns/1ps
module ulpi_usb_tx #(
  parameter int MAX_LEN = 64,
  parameter int TIMEOUT = 4095
) (
  input  logic       CLKOUT,
  input  logic       RESET,
  input  logic       DIR,
  input  logic       NXT,
  output logic       STP,
  output logic [7:0] data_out,
  input  logic       buf_we,
  input  logic [5:0] buf_addr,
  input  logic [7:0] buf_wdata,
  input  logic       tx_start,
  input  logic [3:0] tx_pid,
  input  logic [6:0] tx_len,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_abort
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_CMD,
    S_DATA,
    S_CRCL,
    S_CRCH,
    S_STOP
  } state_t;

  state_t          state;
  logic [7:0]      mem [MAX_LEN];
  logic [3:0]      pid;
  logic [6:0]      len;
  logic            is_data;
  logic [5:0]      idx;
  logic [15:0]     crc;
  logic [TW-1:0]   tcnt;

  logic [15:0]     crc_nx;
  logic [5:0]      idx_inc;
  logic [6:0]      len_c;
  logic            last;
  logic            active;
  logic            expire;
  logic            dir_abort;

  function automatic logic [15:0] crc16_byte(
    input logic [15:0] c,
    input logic [7:0]  d
  );
    logic [15:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      if (r[0] ^ d[i]) r = (r >> 1) ^ 16'hA001;
      else             r = r >> 1;
    end
    return r;
  endfunction

  always_comb begin
    crc_nx  = crc16_byte(crc, data_out);
    idx_inc = idx + 6'd1;
    len_c   = (tx_len > 7'(MAX_LEN)) ? 7'(MAX_LEN) : tx_len;
    last    = ({1'b0, idx} == len - 7'd1);
    active  = state inside {S_WAIT, S_CMD, S_DATA, S_CRCL, S_CRCH};
    expire  = active && !NXT &&
              (tcnt == TW'(TIMEOUT - 1));
    dir_abort = DIR &&
      ((state == S_CMD && NXT) ||
       (state inside {S_DATA, S_CRCL, S_CRCH}));
  end

  // Payload is frozen while a packet is in flight.
  always_ff @(posedge CLKOUT) begin
    if (buf_we && !tx_busy) mem[buf_addr] <= buf_wdata;
  end

  always_ff @(posedge CLKOUT) begin
    if (!RESET) begin
      state    <= S_IDLE;
      STP      <= 1'b0;
      data_out <= 8'h00;
      tx_busy  <= 1'b0;
      tx_done  <= 1'b0;
      tx_abort <= 1'b0;
      crc      <= 16'hFFFF;
      idx      <= 6'd0;
      tcnt     <= '0;
      pid      <= 4'h0;
      len      <= 7'd0;
      is_data  <= 1'b0;
    end else begin
      tx_done  <= 1'b0;
      tx_abort <= 1'b0;
      if (dir_abort || expire) begin
        state    <= S_IDLE;
        tx_abort <= 1'b1;
        tx_busy  <= 1'b0;
        STP      <= 1'b0;
        data_out <= 8'h00;
      end else begin
        if (active) tcnt <= NXT ? '0 : tcnt + 1'b1;
        unique case (state)
          S_IDLE: begin
            if (tx_start) begin
              pid     <= tx_pid;
              len     <= len_c;
              is_data <= (tx_pid[1:0] == 2'b11);
              crc     <= 16'hFFFF;
              idx     <= 6'd0;
              tcnt    <= '0;
              tx_busy <= 1'b1;
              state   <= S_WAIT;
            end
          end
          S_WAIT: begin
            if (!DIR && !NXT) begin
              state    <= S_CMD;
              data_out <= {4'b0100, pid};
            end
          end
          S_CMD: begin
            // DIR without NXT: PHY is sending RXCMD, retry later.
            if (DIR) begin
              state    <= S_WAIT;
              data_out <= 8'h00;
            end else if (NXT) begin
              if (!is_data) begin
                state    <= S_STOP;
                STP      <= 1'b1;
                tx_done  <= 1'b1;
                data_out <= 8'h00;
              end else if (len == 7'd0) begin
                state    <= S_CRCL;
                data_out <= ~crc[7:0];
              end else begin
                state    <= S_DATA;
                data_out <= mem[idx];
              end
            end
          end
          S_DATA: begin
            if (NXT) begin
              crc <= crc_nx;
              idx <= idx_inc;
              if (last) begin
                state    <= S_CRCL;
                data_out <= ~crc_nx[7:0];
              end else begin
                data_out <= mem[idx_inc];
              end
            end
          end
          S_CRCL: begin
            if (NXT) begin
              state    <= S_CRCH;
              data_out <= ~crc[15:8];
            end
          end
          S_CRCH: begin
            if (NXT) begin
              state    <= S_STOP;
              STP      <= 1'b1;
              tx_done  <= 1'b1;
              data_out <= 8'h00;
            end
          end
          S_STOP: begin
            state   <= S_IDLE;
            STP     <= 1'b0;
            tx_busy <= 1'b0;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ulpi_usb_tx.sv
// Bench for ulpi_usb_tx: PHY-side NXT/DIR model, byte capture and
// a packet-level reference built from the USB PID/CRC16 rules.
`timescale 1ns/1ps
module tb_ulpi_usb_tx;

  localparam int TIMEOUT = 4095;

  logic       CLKOUT = 1'b0;
  logic       RESET = 1'b0;
  logic       DIR = 1'b0;
  logic       NXT = 1'b0;
  logic       STP;
  logic [7:0] data_out;
  logic       buf_we = 1'b0;
  logic [5:0] buf_addr = 6'd0;
  logic [7:0] buf_wdata = 8'h00;
  logic       tx_start = 1'b0;
  logic [3:0] tx_pid = 4'h0;
  logic [6:0] tx_len = 7'd0;
  logic       tx_busy;
  logic       tx_done;
  logic       tx_abort;

  ulpi_usb_tx #(.MAX_LEN(64), .TIMEOUT(TIMEOUT)) dut (
    .CLKOUT    (CLKOUT),
    .RESET     (RESET),
    .DIR       (DIR),
    .NXT       (NXT),
    .STP       (STP),
    .data_out  (data_out),
    .buf_we    (buf_we),
    .buf_addr  (buf_addr),
    .buf_wdata (buf_wdata),
    .tx_start  (tx_start),
    .tx_pid    (tx_pid),
    .tx_len    (tx_len),
    .tx_busy   (tx_busy),
    .tx_done   (tx_done),
    .tx_abort  (tx_abort)
  );

  always #8 CLKOUT = ~CLKOUT;

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation did not end");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [3:0]  pid;
    logic [6:0]  len;
    int          stall0;
    int          n;
    logic [31:0] bytes;
  } vec_t;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] ref_buf [64];
  logic [7:0] exp_q [$];
  logic [7:0] got [$];
  int         stall [80];
  int         dir_k, dir_cycles, rst_k, poke_k;
  int         stp_cnt, done_cnt, ab_cnt;
  int         cmd_cnt, cmd_cyc, stp_cyc;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h",
               name, act, req);
    end
  endtask

  task automatic wr(input int a, input logic [7:0] v);
    buf_we    = 1'b1;
    buf_addr  = 6'(a);
    buf_wdata = v;
    ref_buf[a] = v;
    @(negedge CLKOUT);
    buf_we = 1'b0;
  endtask

  task automatic clear_opts();
    for (int i = 0; i < 80; i++) stall[i] = 0;
    dir_k = -1;
    dir_cycles = 0;
    rst_k = -1;
    poke_k = -1;
  endtask

  // Packet as seen on the wire: TXCMD, payload, inverted CRC16.
  task automatic build_exp(input logic [3:0] pid,
                           input int len_in);
    logic [15:0] crc;
    logic [7:0]  b;
    int          n;
    exp_q.delete();
    exp_q.push_back({4'h4, pid});
    if (pid[1:0] == 2'b11) begin
      n = (len_in > 64) ? 64 : len_in;
      crc = 16'hFFFF;
      for (int i = 0; i < n; i++) begin
        b = ref_buf[i];
        exp_q.push_back(b);
        for (int j = 0; j < 8; j++) begin
          if (crc[0] ^ b[j]) crc = (crc >> 1) ^ 16'hA001;
          else               crc = crc >> 1;
        end
      end
      crc = ~crc;
      exp_q.push_back(crc[7:0]);
      exp_q.push_back(crc[15:8]);
    end
  endtask

  task automatic cmp_bytes(input string tag);
    chk({tag, "_len"}, got.size(), exp_q.size());
    for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
      chk($sformatf("%s_byte%0d", tag, i), got[i], exp_q[i]);
      if (got[i] !== exp_q[i]) break;
    end
  endtask

  task automatic run_pkt(input logic [3:0] pid,
                         input logic [6:0] len);
    int         k, stall_left, dir_left, cyc, nexp;
    bit         dir_on, rst_on, after_stp, ended, seen, poked;
    logic [7:0] d, held, prev_d, cmd;
    cmd = {4'b0100, pid};
    build_exp(pid, int'(len));
    nexp = exp_q.size();
    got.delete();
    stp_cnt = 0; done_cnt = 0; ab_cnt = 0;
    cmd_cnt = 0; cmd_cyc = -1; stp_cyc = -1;
    k = 0; stall_left = stall[0]; dir_left = dir_cycles;
    dir_on = 0; rst_on = 0; after_stp = 0; ended = 0;
    seen = 0; poked = 0; held = 8'h00; prev_d = 8'h00;
    tx_start = 1'b1;
    tx_pid = pid;
    tx_len = len;
    @(negedge CLKOUT);
    tx_start = 1'b0;
    chk("busy_rise", tx_busy, 1);
    cyc = 1;
    while (!ended && cyc < 3000) begin
      d = data_out;
      if (tx_done) done_cnt++;
      if (tx_abort) ab_cnt++;
      if (STP) stp_cnt++;
      NXT = 1'b0; DIR = 1'b0;
      tx_start = 1'b0; buf_we = 1'b0;
      if (rst_on) begin
        chk("rst_stp", STP, 0);
        chk("rst_data", d, 0);
        chk("rst_busy", tx_busy, 0);
        chk("rst_done", tx_done, 0);
        chk("rst_abort", tx_abort, 0);
        RESET = 1'b1;
        ended = 1;
      end else if (after_stp) begin
        chk("stp_fall", STP, 0);
        chk("busy_fall", tx_busy, 0);
        ended = 1;
      end else if (tx_abort) begin
        chk("abort_data", d, 0);
        chk("abort_stp", STP, 0);
        chk("abort_busy", tx_busy, 0);
        ended = 1;
      end else if (STP) begin
        stp_cyc = cyc;
        chk("stp_data", d, 0);
        chk("done_at_stp", tx_done, 1);
        chk("busy_at_stp", tx_busy, 1);
        after_stp = 1;
      end else begin
        if (k == 0 && d == cmd && prev_d != cmd) begin
          cmd_cnt++;
          if (cmd_cyc < 0) cmd_cyc = cyc;
        end
        if (rst_k >= 0 && k == rst_k) begin
          RESET = 1'b0;
          rst_on = 1;
        end else if (dir_left > 0 && (dir_on ||
                     (k == dir_k && (k > 0 || d == cmd)))) begin
          DIR = 1'b1;
          dir_on = 1;
          dir_left--;
        end else if (k < nexp && (k > 0 || d == cmd)) begin
          if (poke_k == k && !poked) begin
            tx_start = 1'b1;
            tx_pid = 4'h2;
            tx_len = 7'd5;
            buf_we = 1'b1;
            buf_addr = 6'd0;
            buf_wdata = ~ref_buf[0];
            poked = 1;
          end
          if (!seen) begin
            held = d;
            seen = 1;
          end else if (k > 0) begin
            chk($sformatf("hold_byte%0d", k), d, held);
          end
          if (stall_left > 0) begin
            stall_left--;
          end else begin
            NXT = 1'b1;
            got.push_back(d);
            k++;
            seen = 0;
            stall_left = stall[k];
          end
        end
      end
      prev_d = d;
      cyc++;
      if (!ended) @(negedge CLKOUT);
    end
    if (!ended) begin
      checks++;
      errors++;
      $display("FAIL pkt_end: no STP or abort in %0d cycles", cyc);
    end
    NXT = 1'b0; DIR = 1'b0;
    tx_start = 1'b0; buf_we = 1'b0;
  endtask

  task automatic chk_clean(input string tag);
    chk({tag, "_stp_cnt"}, stp_cnt, 1);
    chk({tag, "_done_cnt"}, done_cnt, 1);
    chk({tag, "_abort_cnt"}, ab_cnt, 0);
  endtask

  vec_t       tab [6];
  logic [7:0] desc [18];
  logic [3:0] pids [5];
  logic [31:0] vb;
  int         cnt;
  bit         stp_seen;

  initial begin
    tab[0] = '{4'h2, 7'd0, 1, 1, 32'h0000_0042};
    tab[1] = '{4'hA, 7'd0, 0, 1, 32'h0000_004A};
    tab[2] = '{4'hE, 7'd5, 0, 1, 32'h0000_004E};
    tab[3] = '{4'hB, 7'd0, 0, 3, 32'h0000_004B};
    tab[4] = '{4'h3, 7'd1, 0, 4, 32'hBF40_0043};
    tab[5] = '{4'hB, 7'd1, 2, 4, 32'hBF40_004B};
    desc = '{8'h12, 8'h01, 8'h00, 8'h02, 8'h00, 8'h00,
             8'h00, 8'h40, 8'h83, 8'h04, 8'h10, 8'h57,
             8'h00, 8'h01, 8'h01, 8'h02, 8'h03, 8'h01};
    pids = '{4'h2, 4'hA, 4'hE, 4'h3, 4'hB};
    for (int i = 0; i < 64; i++) ref_buf[i] = 8'h00;
    clear_opts();

    repeat (3) @(negedge CLKOUT);
    chk("reset_stp", STP, 0);
    chk("reset_data", data_out, 0);
    chk("reset_busy", tx_busy, 0);
    chk("reset_done", tx_done, 0);
    chk("reset_abort", tx_abort, 0);
    RESET = 1'b1;
    @(negedge CLKOUT);
    wr(0, 8'h00);

    for (int i = 0; i < 6; i++) begin
      clear_opts();
      stall[0] = tab[i].stall0;
      run_pkt(tab[i].pid, tab[i].len);
      vb = tab[i].bytes;
      exp_q.delete();
      for (int j = 0; j < tab[i].n; j++)
        exp_q.push_back(vb[8*j +: 8]);
      cmp_bytes($sformatf("vec%0d", i));
      chk_clean($sformatf("vec%0d", i));
      chk($sformatf("vec%0d_cmd_lat", i), cmd_cyc, 2);
      chk($sformatf("vec%0d_dur", i), stp_cyc - cmd_cyc,
          tab[i].n + tab[i].stall0);
    end

    for (int i = 0; i < 18; i++) wr(i, desc[i]);
    clear_opts();
    stall[1] = 3;
    stall[8] = 3;
    stall[20] = 3;
    run_pkt(4'hB, 7'd18);
    build_exp(4'hB, 18);
    cmp_bytes("desc");
    chk_clean("desc");
    chk("desc_dur", stp_cyc - cmd_cyc, 21 + 9);

    clear_opts();
    dir_k = 0;
    dir_cycles = 2;
    run_pkt(4'h3, 7'd4);
    build_exp(4'h3, 4);
    cmp_bytes("backoff");
    chk_clean("backoff");
    chk("backoff_cmd_cnt", cmd_cnt, 2);

    clear_opts();
    dir_k = 6;
    dir_cycles = 1;
    run_pkt(4'h3, 7'd10);
    build_exp(4'h3, 10);
    while (exp_q.size() > 6) void'(exp_q.pop_back());
    cmp_bytes("dirabort");
    chk("dirabort_abort_cnt", ab_cnt, 1);
    chk("dirabort_stp_cnt", stp_cnt, 0);
    chk("dirabort_done_cnt", done_cnt, 0);

    clear_opts();
    rst_k = 4;
    run_pkt(4'hB, 7'd10);
    chk("rstmid_stp_cnt", stp_cnt, 0);
    chk("rstmid_abort_cnt", ab_cnt, 0);
    repeat (2) @(negedge CLKOUT);
    chk("rstmid_idle_busy", tx_busy, 0);
    chk("rstmid_idle_data", data_out, 0);

    clear_opts();
    poke_k = 3;
    run_pkt(4'h3, 7'd8);
    build_exp(4'h3, 8);
    cmp_bytes("poke");
    chk_clean("poke");
    repeat (3) @(negedge CLKOUT);
    chk("poke_idle_busy", tx_busy, 0);
    chk("poke_idle_data", data_out, 0);
    clear_opts();
    run_pkt(4'h3, 7'd8);
    build_exp(4'h3, 8);
    cmp_bytes("bufkeep");
    chk_clean("bufkeep");

    for (int i = 0; i < 64; i++) wr(i, 8'($urandom));
    clear_opts();
    run_pkt(4'h3, 7'd100);
    build_exp(4'h3, 100);
    cmp_bytes("clamp");
    chk_clean("clamp");
    chk("clamp_dur", stp_cyc - cmd_cyc, 67);

    for (int r = 0; r < 20; r++) begin
      for (int i = 0; i < 4; i++)
        wr($urandom_range(0, 63), 8'($urandom));
      clear_opts();
      for (int i = 0; i < 80; i++)
        if ($urandom_range(0, 3) == 0)
          stall[i] = $urandom_range(1, 2);
      run_pkt(pids[$urandom_range(0, 4)],
              7'($urandom_range(0, 70)));
      cmp_bytes($sformatf("rnd%0d", r));
      chk_clean($sformatf("rnd%0d", r));
    end

    DIR = 1'b1;
    tx_start = 1'b1;
    tx_pid = 4'h3;
    tx_len = 7'd4;
    @(negedge CLKOUT);
    tx_start = 1'b0;
    cnt = 0;
    stp_seen = 0;
    for (int n = 0; n < 5000; n++) begin
      if (tx_abort) break;
      if (tx_busy) cnt++;
      if (STP) stp_seen = 1;
      @(negedge CLKOUT);
    end
    chk("timeout_cycles", cnt, TIMEOUT);
    chk("timeout_abort", tx_abort, 1);
    chk("timeout_busy", tx_busy, 0);
    chk("timeout_no_stp", stp_seen, 0);
    DIR = 1'b0;
    repeat (2) @(negedge CLKOUT);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
